div_recon_16bit: RTL and testbench



---
 rtl/div_recon_16bit.sv | 110 +++++++++++
 tb/tb_div_recon_16bit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_recon_16bit.sv
// Sequential dividend reconstruction: dividend = quotient * divisor + remainder, one divisor bit per clock.
// Define DIV_RECON_CHECK_EN to flag tuples that no legal 16/8 divide could have produced on err.
module div_recon_16bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] quotient,
    input  logic [7:0]  divisor,
    input  logic [15:0] remainder,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] dividend,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [15:0] r_quot;
    logic [7:0]  r_div;
    logic [23:0] r_acc;
    logic [2:0]  r_cnt;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_err;

    logic [23:0] w_addend;
    logic [23:0] w_acc_next;
    logic        w_err_next;

    // Partial product for the current divisor bit; the 24-bit sum cannot carry out.
    assign w_addend   = r_div[r_cnt] ? ({8'd0, r_quot} << r_cnt) : 24'd0;
    assign w_acc_next = r_acc + w_addend;

`ifdef DIV_RECON_CHECK_EN
    logic r_bad;
    logic w_bad_in;

    // Operand legality is judged at accept so only the overflow test waits for the final sum.
    assign w_bad_in   = (divisor != 8'd0) ? (remainder >= {8'd0, divisor}) : (quotient != 16'd0);
    assign w_err_next = r_bad || (w_acc_next > 24'h00FFFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bad <= 1'b0;
        end else if (r_state == S_IDLE && in_valid) begin
            r_bad <= w_bad_in;
        end
    end
`else
    assign w_err_next = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_acc       <= 24'd0;
            r_cnt       <= 3'd0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_quot     <= quotient;
                        r_div      <= divisor;
                        r_acc      <= {8'd0, remainder};
                        r_cnt      <= 3'd0;
                        r_err      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_err       <= w_err_next;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign dividend  = r_acc;
    assign err       = r_err;

endmodule

// File: tb/tb_div_recon_16bit.sv
// Randomized and directed bench for div_recon_16bit against an arithmetic transaction model.
// Honours DIV_RECON_CHECK_EN the same way the design does.
module tb_div_recon_16bit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] quotient;
    logic [7:0]  divisor;
    logic [15:0] remainder;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] dividend;
    logic        err;

`ifdef DIV_RECON_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    div_recon_16bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quotient  (quotient),
        .divisor   (divisor),
        .remainder (remainder),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dividend  (dividend),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;
    bit chk_en = 1'b0;

    // Transaction-level model state
    int          m_st = 0;
    int          m_left = 0;
    logic        m_in_ready = 1'b1;
    logic        m_out_valid = 1'b0;
    logic [23:0] m_div = 24'd0;
    logic        m_err = 1'b0;
    logic [23:0] m_pend_d = 24'd0;
    logic        m_pend_e = 1'b0;

    function automatic logic [23:0] exp_d(input logic [15:0] q, input logic [7:0] b, input logic [15:0] r);
        int unsigned v;
        v = int'(q) * int'(b) + int'(r);
        return v[23:0];
    endfunction

    function automatic logic exp_e(input logic [15:0] q, input logic [7:0] b, input logic [15:0] r);
        logic [23:0] d;
        d = exp_d(q, b, r);
        return CHK && ((b != 0 && r >= {8'd0, b}) || (b == 0 && q != 0) || (d > 24'h00FFFF));
    endfunction

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] expv);
        nvec++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_st = 0; m_in_ready = 1'b1; m_out_valid = 1'b0; m_div = 24'd0; m_err = 1'b0;
            end else begin
                case (m_st)
                    0: if (in_valid) begin
                        m_pend_d = exp_d(quotient, divisor, remainder);
                        m_pend_e = exp_e(quotient, divisor, remainder);
                        m_left = 8; m_st = 1; m_in_ready = 1'b0;
                    end
                    1: begin
                        m_left--;
                        if (m_left == 0) begin
                            m_st = 2; m_out_valid = 1'b1; m_div = m_pend_d; m_err = m_pend_e;
                        end
                    end
                    default: if (out_ready) begin
                        m_st = 0; m_out_valid = 1'b0; m_in_ready = 1'b1;
                    end
                endcase
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("in_ready", {23'd0, in_ready}, {23'd0, m_in_ready});
                chk("out_valid", {23'd0, out_valid}, {23'd0, m_out_valid});
                if (m_out_valid) begin
                    chk("dividend", dividend, m_div);
                    chk("err", {23'd0, err}, {23'd0, m_err});
                end
            end
        end
    end

    task automatic send(input logic [15:0] q, input logic [7:0] b, input logic [15:0] r);
        int n;
        @(negedge clk);
        quotient = q; divisor = b; remainder = r; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            nvec++; nfail++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic dir(input string nm, input logic [15:0] q, input logic [7:0] b, input logic [15:0] r,
                       input logic [23:0] litd, input logic lite);
        int lat;
        out_ready = 1'b1;
        send(q, b, r);
        wait_valid(lat);
        chk({nm, "_latency"}, 24'(lat), 24'd8);
        chk({nm, "_dividend"}, dividend, litd);
        chk({nm, "_err"}, {23'd0, err}, {23'd0, CHK & lite});
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int n;
        logic [15:0] q;
        logic [7:0]  b;
        logic [15:0] r;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        quotient = 16'd0; divisor = 8'd0; remainder = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {23'd0, in_ready}, 24'd1);
        chk("rst_out_valid", {23'd0, out_valid}, 24'd0);
        chk("rst_dividend", dividend, 24'd0);
        chk("rst_err", {23'd0, err}, 24'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        dir("basic", 16'h00F6, 8'h05, 16'h0002, 24'h0004D0, 1'b0);
        dir("dz_ok", 16'h0000, 8'h00, 16'h1234, 24'h001234, 1'b0);
        dir("dz_bad", 16'h0001, 8'h00, 16'h1234, 24'h001234, 1'b1);
        dir("max", 16'hFFFF, 8'hFF, 16'hFFFF, 24'hFFFF00, 1'b1);
        dir("zero", 16'h0000, 8'hFF, 16'h0000, 24'h000000, 1'b0);
        dir("bad_rem", 16'd10, 8'd7, 16'd7, 24'h00004D, 1'b1);

        // Backpressure: hold the result while new tuples are offered
        out_ready = 1'b0;
        send(16'h0123, 8'h0A, 16'h0003);
        wait_valid(lat);
        chk("bp_latency", 24'(lat), 24'd8);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            quotient = 16'($urandom); divisor = 8'($urandom); remainder = 16'($urandom);
            @(negedge clk);
            chk("bp_hold", dividend, 24'h000B61);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {23'd0, in_ready}, 24'd1);
        dir("after_bp", 16'h0040, 8'h81, 16'h0011, 24'h002051, 1'b0);

        // Reset on the 4th CALC edge discards the tuple
        send(16'h1111, 8'h22, 16'h0005);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_dividend", dividend, 24'd0);
        chk("midrst_in_ready", {23'd0, in_ready}, 24'd1);
        repeat (12) @(negedge clk);
        dir("post_rst", 16'd3, 8'd4, 16'd1, 24'd13, 1'b0);

        // Random tuples with random backpressure
        for (int t = 0; t < 40; t++) begin
            b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            q = 16'($urandom);
            if (b == 0 && $urandom_range(0, 1) == 1) q = 16'd0;
            if ($urandom_range(0, 2) != 0 && b != 0) r = 16'($urandom % b);
            else r = 16'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(q, b, r);
            n = 0;
            while (n < 200) begin
                @(negedge clk);
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) break;
                n++;
            end
            if (n >= 200) begin
                nvec++; nfail++;
                $display("FAIL rand_timeout: out_valid=%b out_ready=%b, required handshake", out_valid, out_ready);
            end
            @(negedge clk);
            out_ready = 1'b1;
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
